// File: rtl/rcvr_addr_arb_pkg.sv
// rtl/rcvr_addr_arb_pkg.sv - shared constants for the freed-address recycle arbiter
package rcvr_addr_arb_pkg;

  localparam int ADDR_LENTH_DEF = 12;
  localparam int NUM_RCVR_SRC   = 5;
  localparam int DROP_SRC_IDX   = 4;
  localparam int SRC_IDX_W      = 3;
  localparam int NULL_ADDR      = 0;

  // Round-robin successor, wrapping past the drop path back to channel 0.
  function automatic logic [SRC_IDX_W-1:0] nextSrc(input logic [SRC_IDX_W-1:0] cur);
    return (cur == SRC_IDX_W'(NUM_RCVR_SRC - 1)) ? '0 : cur + SRC_IDX_W'(1);
  endfunction

endpackage

// File: rtl/rcvr_addr_arb_fifo.sv
// rtl/rcvr_addr_arb_fifo.sv - per-source elastic FIFO for freed addresses
module rcvr_addr_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oPopData,
  output logic             oFull,
  output logic             oEmpty,
  output logic             oEmptyNxt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   countNxt;
  logic             pushOk;
  logic             popOk;

  // A full FIFO still takes a push when the same cycle frees a slot.
  assign popOk     = iPop & ~oEmpty;
  assign pushOk    = iPush & (~oFull | popOk);
  assign countNxt  = count + (PTR_W+1)'(pushOk) - (PTR_W+1)'(popOk);
  assign oFull     = (count == (PTR_W+1)'(DEPTH));
  assign oEmpty    = (count == '0);
  assign oEmptyNxt = (countNxt == '0);
  assign oPopData  = mem[rdPtr];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
      count <= countNxt;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst && pushOk) mem[wrPtr] <= iPushData;
  end

endmodule

// File: rtl/rcvr_addr_arb.sv
// rtl/rcvr_addr_arb.sv - round-robin return of freed block addresses to the AddrCtrl free list
module rcvr_addr_arb
  import rcvr_addr_arb_pkg::*;
#(
  parameter int ADDR_LENTH = ADDR_LENTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [ADDR_LENTH-1:0]   iRcvrAddr0,
  input  logic [ADDR_LENTH-1:0]   iRcvrAddr1,
  input  logic [ADDR_LENTH-1:0]   iRcvrAddr2,
  input  logic [ADDR_LENTH-1:0]   iRcvrAddr3,
  input  logic                    iRcvrAddrVld0,
  input  logic                    iRcvrAddrVld1,
  input  logic                    iRcvrAddrVld2,
  input  logic                    iRcvrAddrVld3,
  input  logic [ADDR_LENTH-1:0]   iDropRcvrAddr,
  input  logic                    iDropRcvrAddrVld,
  output logic [ADDR_LENTH-1:0]   oFreeAddr,
  output logic                    oFreeAddrVld,
  input  logic                    iFreeAddrRdy,
  output logic [NUM_RCVR_SRC-1:0] oOvfl,
  input  logic                    iOvflClr,
  output logic [CNT_WIDTH-1:0]    oRcvrCnt,
  output logic                    oIdle
);

  logic [ADDR_LENTH-1:0]   srcAddr  [NUM_RCVR_SRC];
  logic [ADDR_LENTH-1:0]   fifoData [NUM_RCVR_SRC];
  logic [NUM_RCVR_SRC-1:0] srcVld;
  logic [NUM_RCVR_SRC-1:0] pushReq;
  logic [NUM_RCVR_SRC-1:0] popReq;
  logic [NUM_RCVR_SRC-1:0] fifoFull;
  logic [NUM_RCVR_SRC-1:0] fifoEmpty;
  logic [NUM_RCVR_SRC-1:0] fifoEmptyNxt;
  logic [NUM_RCVR_SRC-1:0] ovflEvt;

  logic [SRC_IDX_W-1:0] rrPtr;
  logic [SRC_IDX_W-1:0] grantIdx;
  logic [SRC_IDX_W-1:0] cand;
  logic [SRC_IDX_W:0]   candSum;
  logic                 grantVld;
  logic                 load;
  logic                 xfer;
  logic                 freeVldNxt;

  assign srcAddr[0]            = iRcvrAddr0;
  assign srcAddr[1]            = iRcvrAddr1;
  assign srcAddr[2]            = iRcvrAddr2;
  assign srcAddr[3]            = iRcvrAddr3;
  assign srcAddr[DROP_SRC_IDX] = iDropRcvrAddr;
  assign srcVld = {iDropRcvrAddrVld, iRcvrAddrVld3, iRcvrAddrVld2, iRcvrAddrVld1, iRcvrAddrVld0};

  for (genvar s = 0; s < NUM_RCVR_SRC; s++) begin : gSrc
    // The null pointer is never a real block, so it is dropped before it can occupy a slot.
    assign pushReq[s] = srcVld[s] & (srcAddr[s] != ADDR_LENTH'(NULL_ADDR));
    assign popReq[s]  = load & (grantIdx == SRC_IDX_W'(s));
    assign ovflEvt[s] = pushReq[s] & fifoFull[s] & ~popReq[s];

    rcvr_addr_fifo #(
      .WIDTH (ADDR_LENTH),
      .DEPTH (FIFO_DEPTH)
    ) uFifo (
      .iClk      (iClk),
      .iRst      (iRst),
      .iPush     (pushReq[s]),
      .iPushData (srcAddr[s]),
      .iPop      (popReq[s]),
      .oPopData  (fifoData[s]),
      .oFull     (fifoFull[s]),
      .oEmpty    (fifoEmpty[s]),
      .oEmptyNxt (fifoEmptyNxt[s])
    );
  end

  // First non-empty FIFO at or after rrPtr, wrapping modulo the source count.
  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    candSum  = '0;
    cand     = '0;
    for (int k = 0; k < NUM_RCVR_SRC; k++) begin
      candSum = {1'b0, rrPtr} + (SRC_IDX_W+1)'(k);
      if (candSum >= (SRC_IDX_W+1)'(NUM_RCVR_SRC)) candSum = candSum - (SRC_IDX_W+1)'(NUM_RCVR_SRC);
      cand = candSum[SRC_IDX_W-1:0];
      if (!grantVld && !fifoEmpty[cand]) begin
        grantVld = 1'b1;
        grantIdx = cand;
      end
    end
  end

  assign xfer       = oFreeAddrVld & iFreeAddrRdy;
  assign load       = (~oFreeAddrVld | iFreeAddrRdy) & grantVld;
  assign freeVldNxt = load | (oFreeAddrVld & ~iFreeAddrRdy);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oFreeAddr    <= '0;
      oFreeAddrVld <= 1'b0;
      rrPtr        <= '0;
      oRcvrCnt     <= '0;
      oOvfl        <= '0;
      oIdle        <= 1'b1;
    end else begin
      if (load) begin
        oFreeAddr <= fifoData[grantIdx];
        rrPtr     <= nextSrc(grantIdx);
      end
      oFreeAddrVld <= freeVldNxt;
      if (xfer) oRcvrCnt <= oRcvrCnt + CNT_WIDTH'(1);
      // A fresh overflow wins over a coincident clear on the same bit.
      oOvfl <= ovflEvt | (oOvfl & ~{NUM_RCVR_SRC{iOvflClr}});
      oIdle <= (&fifoEmptyNxt) & ~freeVldNxt;
    end
  end

endmodule

// File: tb/tb_rcvr_addr_arb.sv
// tb/tb_rcvr_addr_arb.sv - directed self-checking bench for rcvr_addr_arb
module tb_rcvr_addr_arb;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [11:0] iRcvrAddr0, iRcvrAddr1, iRcvrAddr2, iRcvrAddr3, iDropRcvrAddr;
  logic        iRcvrAddrVld0, iRcvrAddrVld1, iRcvrAddrVld2, iRcvrAddrVld3, iDropRcvrAddrVld;
  logic [11:0] oFreeAddr;
  logic        oFreeAddrVld;
  logic        iFreeAddrRdy;
  logic [4:0]  oOvfl;
  logic        iOvflClr;
  logic [15:0] oRcvrCnt;
  logic        oIdle;

  int nChk = 0;
  int nBad = 0;
  logic [11:0] expQ [5];

  always #5 iClk = ~iClk;

  rcvr_addr_arb #(.ADDR_LENTH(12), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .iClk(iClk), .iRst(iRst),
    .iRcvrAddr0(iRcvrAddr0), .iRcvrAddr1(iRcvrAddr1), .iRcvrAddr2(iRcvrAddr2), .iRcvrAddr3(iRcvrAddr3),
    .iRcvrAddrVld0(iRcvrAddrVld0), .iRcvrAddrVld1(iRcvrAddrVld1),
    .iRcvrAddrVld2(iRcvrAddrVld2), .iRcvrAddrVld3(iRcvrAddrVld3),
    .iDropRcvrAddr(iDropRcvrAddr), .iDropRcvrAddrVld(iDropRcvrAddrVld),
    .oFreeAddr(oFreeAddr), .oFreeAddrVld(oFreeAddrVld), .iFreeAddrRdy(iFreeAddrRdy),
    .oOvfl(oOvfl), .iOvflClr(iOvflClr), .oRcvrCnt(oRcvrCnt), .oIdle(oIdle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic clrIn;
    iRcvrAddr0 = '0; iRcvrAddr1 = '0; iRcvrAddr2 = '0; iRcvrAddr3 = '0; iDropRcvrAddr = '0;
    iRcvrAddrVld0 = 1'b0; iRcvrAddrVld1 = 1'b0; iRcvrAddrVld2 = 1'b0; iRcvrAddrVld3 = 1'b0;
    iDropRcvrAddrVld = 1'b0;
    iOvflClr = 1'b0;
  endtask

  task automatic doReset;
    clrIn();
    iFreeAddrRdy = 1'b1;
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
  endtask

  initial begin
    clrIn();
    iFreeAddrRdy = 1'b1;
    iRst = 1'b0;

    // 1: single address, two-cycle latency, idle returns
    doReset();
    chk("rst vld", 32'(oFreeAddrVld), 32'd0);
    chk("rst addr", 32'(oFreeAddr), 32'h0);
    chk("rst ovfl", 32'(oOvfl), 32'h0);
    chk("rst cnt", 32'(oRcvrCnt), 32'd0);
    chk("rst idle", 32'(oIdle), 32'd1);
    iRcvrAddrVld0 = 1'b1; iRcvrAddr0 = 12'h005;
    tick();
    clrIn();
    chk("t1 c2 vld", 32'(oFreeAddrVld), 32'd0);
    chk("t1 c2 idle", 32'(oIdle), 32'd0);
    tick();
    chk("t1 c3 vld", 32'(oFreeAddrVld), 32'd1);
    chk("t1 c3 addr", 32'(oFreeAddr), 32'h005);
    tick();
    chk("t1 c4 vld", 32'(oFreeAddrVld), 32'd0);
    chk("t1 c4 cnt", 32'(oRcvrCnt), 32'd1);
    chk("t1 c4 idle", 32'(oIdle), 32'd1);

    // 2: all five sources push together, drained in source order
    doReset();
    iRcvrAddrVld0 = 1'b1; iRcvrAddr0 = 12'h101;
    iRcvrAddrVld1 = 1'b1; iRcvrAddr1 = 12'h202;
    iRcvrAddrVld2 = 1'b1; iRcvrAddr2 = 12'h303;
    iRcvrAddrVld3 = 1'b1; iRcvrAddr3 = 12'h404;
    iDropRcvrAddrVld = 1'b1; iDropRcvrAddr = 12'h505;
    tick();
    clrIn();
    tick();
    expQ[0] = 12'h101; expQ[1] = 12'h202; expQ[2] = 12'h303; expQ[3] = 12'h404; expQ[4] = 12'h505;
    for (int i = 0; i < 5; i++) begin
      chk("t2 vld", 32'(oFreeAddrVld), 32'd1);
      chk("t2 addr", 32'(oFreeAddr), 32'(expQ[i]));
      tick();
    end
    chk("t2 end vld", 32'(oFreeAddrVld), 32'd0);
    chk("t2 cnt", 32'(oRcvrCnt), 32'd5);
    chk("t2 ovfl", 32'(oOvfl), 32'h0);

    // 3: source 2 overflows behind a stalled output stage; set beats clear
    doReset();
    iFreeAddrRdy = 1'b0;
    iRcvrAddrVld0 = 1'b1; iRcvrAddr0 = 12'h0AA;
    tick();
    clrIn();
    iRcvrAddrVld2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iRcvrAddr2 = 12'h011 + 12'(i);
      tick();
    end
    chk("t3 ovfl set", 32'(oOvfl), 32'h04);
    chk("t3 held addr", 32'(oFreeAddr), 32'h0AA);
    iRcvrAddr2 = 12'h016;
    iOvflClr = 1'b1;
    tick();
    iRcvrAddrVld2 = 1'b0;
    chk("t3 set wins", 32'(oOvfl), 32'h04);
    iFreeAddrRdy = 1'b1;
    expQ[0] = 12'h0AA; expQ[1] = 12'h011; expQ[2] = 12'h012; expQ[3] = 12'h013; expQ[4] = 12'h014;
    for (int i = 0; i < 5; i++) begin
      chk("t3 vld", 32'(oFreeAddrVld), 32'd1);
      chk("t3 addr", 32'(oFreeAddr), 32'(expQ[i]));
      tick();
      iOvflClr = 1'b0;
    end
    chk("t3 end vld", 32'(oFreeAddrVld), 32'd0);
    chk("t3 ovfl clr", 32'(oOvfl), 32'h0);
    chk("t3 cnt", 32'(oRcvrCnt), 32'd5);

    // 4: null address on the drop path is ignored
    doReset();
    iDropRcvrAddrVld = 1'b1; iDropRcvrAddr = 12'h000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 vld", 32'(oFreeAddrVld), 32'd0);
      chk("t4 idle", 32'(oIdle), 32'd1);
      chk("t4 ovfl", 32'(oOvfl), 32'h0);
    end
    clrIn();
    tick();
    tick();
    chk("t4 vld late", 32'(oFreeAddrVld), 32'd0);
    chk("t4 cnt", 32'(oRcvrCnt), 32'd0);

    // 5: output held stable under backpressure; RR from ptr=2 serves 3 before 1
    doReset();
    iFreeAddrRdy = 1'b0;
    iRcvrAddrVld1 = 1'b1; iRcvrAddr1 = 12'h0B1;
    tick();
    iRcvrAddr1 = 12'h0B2;
    iRcvrAddrVld3 = 1'b1; iRcvrAddr3 = 12'h0C3;
    tick();
    clrIn();
    for (int i = 0; i < 4; i++) begin
      chk("t5 hold vld", 32'(oFreeAddrVld), 32'd1);
      chk("t5 hold addr", 32'(oFreeAddr), 32'h0B1);
      tick();
    end
    iFreeAddrRdy = 1'b1;
    expQ[0] = 12'h0B1; expQ[1] = 12'h0C3; expQ[2] = 12'h0B2;
    for (int i = 0; i < 3; i++) begin
      chk("t5 vld", 32'(oFreeAddrVld), 32'd1);
      chk("t5 addr", 32'(oFreeAddr), 32'(expQ[i]));
      tick();
    end
    chk("t5 end vld", 32'(oFreeAddrVld), 32'd0);
    chk("t5 cnt", 32'(oRcvrCnt), 32'd3);

    // 6: reset mid-flight with three FIFOs loaded (ptr=2 from the previous test)
    iFreeAddrRdy = 1'b0;
    iRcvrAddrVld0 = 1'b1; iRcvrAddr0 = 12'h0D0;
    iRcvrAddrVld1 = 1'b1; iRcvrAddr1 = 12'h0D1;
    iRcvrAddrVld2 = 1'b1; iRcvrAddr2 = 12'h0D2;
    iRcvrAddrVld3 = 1'b1; iRcvrAddr3 = 12'h0D3;
    tick();
    clrIn();
    tick();
    chk("t6 pre vld", 32'(oFreeAddrVld), 32'd1);
    chk("t6 pre addr", 32'(oFreeAddr), 32'h0D2);
    chk("t6 pre cnt", 32'(oRcvrCnt), 32'd3);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("t6 rst vld", 32'(oFreeAddrVld), 32'd0);
    chk("t6 rst addr", 32'(oFreeAddr), 32'h0);
    chk("t6 rst cnt", 32'(oRcvrCnt), 32'd0);
    chk("t6 rst ovfl", 32'(oOvfl), 32'h0);
    chk("t6 rst idle", 32'(oIdle), 32'd1);
    iFreeAddrRdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6 no stale", 32'(oFreeAddrVld), 32'd0);
      chk("t6 idle", 32'(oIdle), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule
